// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: shared widths, tag/config payload and the requantization
// function used by the drain lanes (and reusable by later bias/scale units).
package psum_drain_pkg;

    localparam int unsigned SUM_W   = 24;
    localparam int unsigned ACT_W   = 8;
    localparam int unsigned SHIFT_W = 5;

    // Saturation bounds expressed at accumulator width for signed compares.
    localparam logic signed [SUM_W-1:0] ACT_MAX = SUM_W'((2 ** (ACT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACT_MIN = SUM_W'(-(2 ** (ACT_W - 1)));

    // Row tag plus the per-row config that travels with it.
    typedef struct packed {
        logic               valid;
        logic [SHIFT_W-1:0] shift;
        logic               relu;
    } tag_t;

    // Arithmetic right shift (floor), optional ReLU, saturate to ACT_W signed.
    function automatic logic [ACT_W-1:0] requant(
        input logic [SUM_W-1:0]   sum,
        input logic [SHIFT_W-1:0] shift,
        input logic               relu
    );
        logic signed [SUM_W-1:0] x;
        x = $signed(sum) >>> shift;
        if (relu && x[SUM_W-1]) begin
            x = '0;
        end
        if (x > ACT_MAX) begin
            requant = ACT_W'(ACT_MAX);
        end else if (x < ACT_MIN) begin
            requant = ACT_W'(ACT_MIN);
        end else begin
            requant = ACT_W'(x);
        end
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// psum_drain_if: input partial-sum bus and valid/ready activation output.
//   i_valid/i_sums/i_shift/i_relu : skewed partial sums from the array
//   o_valid/o_ready/o_act         : FIFO head row handshake
//   o_count/o_overflow            : FIFO occupancy and sticky drop flag
// slave = drain block, master = array/consumer side.
interface psum_drain_if
    import psum_drain_pkg::*;
#(
    parameter int unsigned COLS  = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

    logic                     i_valid;
    logic [COLS*SUM_W-1:0]    i_sums;
    logic [SHIFT_W-1:0]       i_shift;
    logic                     i_relu;
    logic                     o_valid;
    logic                     o_ready;
    logic [COLS*ACT_W-1:0]    o_act;
    logic [COUNT_W-1:0]       o_count;
    logic                     o_overflow;

    modport master (
        output i_valid, i_sums, i_shift, i_relu, o_ready,
        input  o_valid, o_act, o_count, o_overflow
    );

    modport slave (
        input  i_valid, i_sums, i_shift, i_relu, o_ready,
        output o_valid, o_act, o_count, o_overflow
    );
endinterface

// File: rtl/psum_drain_row_fifo.sv
// psum_drain_row_fifo: synchronous row FIFO, power-of-two DEPTH.
//   push_i/data_i : write request (accepted when not full, or full with a pop)
//   pop_i         : read request (ignored when empty)
//   data_o        : head row; full_o/empty_o/count_o : registered status
module psum_drain_row_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot the same edge, so a full FIFO can still accept.
    always_comb begin
        do_pop  = pop_i & ~empty_q;
        do_push = push_i & (~full_q | do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage, pointers and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;
endmodule

// File: rtl/psum_drain.sv
// psum_drain: deskews the array's bottom-row partial sums into aligned rows,
// requantizes each column to 8-bit activations and buffers rows in a FIFO.
//   clock/reset : system clock, synchronous active-high reset
//   bus (slave) : skewed sums in, valid/ready activations out, count, overflow
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int unsigned COLS  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    psum_drain_if.slave bus
);
    localparam int unsigned ROW_W   = COLS * ACT_W;
    localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

    tag_t                        in_tag;
    tag_t                        aligned_tag;
    logic [COLS-1:0][SUM_W-1:0]  aligned_sum;
    logic [ROW_W-1:0]            row_act_c;
    logic [ROW_W-1:0]            head_row;
    logic [COUNT_W-1:0]          fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        drop;
    logic                        overflow_q;
    logic                        overflow_d;

    assign in_tag = '{valid: bus.i_valid, shift: bus.i_shift, relu: bus.i_relu};

    // Column j arrives j cycles after its tag; COLS-1-j registers line it up
    // with the last column, and the FIFO write is the final stage for all.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int unsigned STAGES = COLS - 1 - j;
        if (STAGES == 0) begin : g_direct
            assign aligned_sum[j] = bus.i_sums[j*SUM_W +: SUM_W];
        end else begin : g_chain
            logic [SUM_W-1:0] chain_q [STAGES];
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int unsigned k = 0; k < STAGES; k++) begin
                        chain_q[k] <= '0;
                    end
                end else begin
                    chain_q[0] <= bus.i_sums[j*SUM_W +: SUM_W];
                    for (int unsigned k = 1; k < STAGES; k++) begin
                        chain_q[k] <= chain_q[k-1];
                    end
                end
            end
            assign aligned_sum[j] = chain_q[STAGES-1];
        end
    end

    // Tag and row config ride alongside column 0 so they are frozen at tag time.
    if (COLS == 1) begin : g_tag_direct
        assign aligned_tag = in_tag;
    end else begin : g_tag_pipe
        tag_t tag_q [COLS-1];
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int unsigned k = 0; k < COLS - 1; k++) begin
                    tag_q[k] <= '0;
                end
            end else begin
                tag_q[0] <= in_tag;
                for (int unsigned k = 1; k < COLS - 1; k++) begin
                    tag_q[k] <= tag_q[k-1];
                end
            end
        end
        assign aligned_tag = tag_q[COLS-2];
    end

    // Requant lanes on the aligned stage.
    always_comb begin
        row_act_c = '0;
        for (int unsigned j = 0; j < COLS; j++) begin
            row_act_c[j*ACT_W +: ACT_W] = requant(aligned_sum[j], aligned_tag.shift,
                                                  aligned_tag.relu);
        end
    end

    assign pop = bus.o_ready & ~fifo_empty;

    psum_drain_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (aligned_tag.valid),
        .data_i  (row_act_c),
        .pop_i   (pop),
        .data_o  (head_row),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky drop flag: aligned row with a full FIFO and no pop that cycle.
    always_comb begin
        drop       = aligned_tag.valid & fifo_full & ~pop;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_valid    = ~fifo_empty;
    assign bus.o_act      = head_row;
    assign bus.o_count    = fifo_count;
    assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed bench for psum_drain (COLS=4, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_psum_drain;
    localparam int unsigned COLS  = 4;
    localparam int unsigned DEPTH = 4;

    logic clock;
    logic reset;

    psum_drain_if #(.COLS(COLS), .DEPTH(DEPTH)) bus ();

    psum_drain #(.COLS(COLS), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp;
    int          n_err;
    int          cyc;
    int          nrows;
    int          r_start [64];
    logic [95:0] r_sums  [64];
    logic [4:0]  r_shift [64];
    logic        r_relu  [64];

    // Comparison point: counts and reports a mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_act(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic add_row(input int start, input int s0, input int s1, input int s2,
                           input int s3, input logic [4:0] sh, input logic rl);
        r_start[nrows] = start;
        r_sums[nrows]  = {24'(s3), 24'(s2), 24'(s1), 24'(s0)};
        r_shift[nrows] = sh;
        r_relu[nrows]  = rl;
        nrows++;
    endtask

    // Present every scheduled row's column j on slice j in cycle start+j.
    task automatic drive();
        logic [95:0] s;
        logic        v;
        logic [4:0]  sh;
        logic        rl;
        s  = {4{24'h5A5A5A}};
        v  = 1'b0;
        sh = 5'd31;
        rl = 1'b1;
        for (int r = 0; r < nrows; r++) begin
            for (int j = 0; j < 4; j++) begin
                if (cyc == r_start[r] + j) begin
                    s[j*24 +: 24] = r_sums[r][j*24 +: 24];
                end
            end
            if (cyc == r_start[r]) begin
                v  = 1'b1;
                sh = r_shift[r];
                rl = r_relu[r];
            end
        end
        bus.i_sums  = s;
        bus.i_valid = v;
        bus.i_shift = sh;
        bus.i_relu  = rl;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
        drive();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        n_cmp = 0;
        n_err = 0;
        nrows = 0;
        cyc   = 0;
        reset = 1'b1;
        bus.o_ready = 1'b0;
        drive();
        repeat (3) next_cycle();
        reset = 1'b0;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_act", bus.o_act, 32'd0);
        chk("rst_count", 32'(bus.o_count), 32'd0);
        chk("rst_ovf", 32'(bus.o_overflow), 32'd0);
        next_cycle();
        chk("post_rst_valid", 32'(bus.o_valid), 32'd0);

        // Single row, shift 3, latency 4.
        c0 = cyc;
        add_row(c0, 1000, 2000, -300, -1, 5'd3, 1'b0);
        drive();
        repeat (3) begin
            next_cycle();
            chk("t1_latency_wait", 32'(bus.o_valid), 32'd0);
        end
        next_cycle();
        chk("t1_valid", 32'(bus.o_valid), 32'd1);
        chk("t1_act", bus.o_act, 32'hFFDA7F7D);
        chk("t1_count", 32'(bus.o_count), 32'd1);
        bus.o_ready = 1'b1;
        next_cycle();
        chk("t1_popped_valid", 32'(bus.o_valid), 32'd0);
        chk("t1_popped_count", 32'(bus.o_count), 32'd0);
        bus.o_ready = 1'b0;

        // ReLU row then saturation row back-to-back with differing config.
        c0 = cyc;
        add_row(c0, 1000, 2000, -300, -1, 5'd0, 1'b1);
        add_row(c0 + 1, 127, 128, -129, 0, 5'd0, 1'b0);
        drive();
        repeat (6) next_cycle();
        chk("t2_count", 32'(bus.o_count), 32'd2);
        chk("t2_relu_act", bus.o_act, 32'h00007F7F);
        bus.o_ready = 1'b1;
        next_cycle();
        chk("t2_sat_act", bus.o_act, 32'h00807F7F);
        chk("t2_count_after_pop", 32'(bus.o_count), 32'd1);
        next_cycle();
        chk("t2_empty", 32'(bus.o_valid), 32'd0);

        // Eight back-to-back rows streaming with o_ready high.
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            add_row(c0 + k, 8 * (k + 1), 16 * (k + 1), 24 * (k + 1), 32 * (k + 1), 5'd3, 1'b0);
        end
        drive();
        for (int i = 0; i < 14; i++) begin
            next_cycle();
            if (cyc >= c0 + 4 && cyc < c0 + 12) begin
                int k;
                k = cyc - c0 - 4;
                chk("t3_valid", 32'(bus.o_valid), 32'd1);
                chk("t3_act", bus.o_act, mk_act(k + 1, 2 * (k + 1), 3 * (k + 1), 4 * (k + 1)));
                chk("t3_count_le1", 32'(bus.o_count <= 3'd1), 32'd1);
                chk("t3_ovf", 32'(bus.o_overflow), 32'd0);
            end else begin
                chk("t3_idle_valid", 32'(bus.o_valid), 32'd0);
            end
        end
        bus.o_ready = 1'b0;

        // Five rows into a 4-deep FIFO with o_ready low: fifth dropped.
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            add_row(c0 + k, 4 * k + 1, 4 * k + 2, 4 * k + 3, 4 * k + 4, 5'd0, 1'b0);
        end
        drive();
        repeat (7) next_cycle();
        chk("t4_count_full", 32'(bus.o_count), 32'd4);
        chk("t4_ovf_before", 32'(bus.o_overflow), 32'd0);
        next_cycle();
        chk("t4_ovf_set", 32'(bus.o_overflow), 32'd1);
        chk("t4_count_held", 32'(bus.o_count), 32'd4);
        bus.o_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_drain_valid", 32'(bus.o_valid), 32'd1);
            chk("t4_drain_act", bus.o_act, mk_act(4 * k + 1, 4 * k + 2, 4 * k + 3, 4 * k + 4));
            next_cycle();
        end
        chk("t4_drained_valid", 32'(bus.o_valid), 32'd0);
        chk("t4_drained_count", 32'(bus.o_count), 32'd0);
        chk("t4_ovf_sticky", 32'(bus.o_overflow), 32'd1);
        bus.o_ready = 1'b0;

        // Clear the sticky flag, then push into a full FIFO with a same-cycle pop.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        chk("t5_ovf_cleared", 32'(bus.o_overflow), 32'd0);
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            add_row(c0 + k, 10 * k + 1, 10 * k + 2, 10 * k + 3, 10 * k + 4, 5'd0, 1'b0);
        end
        drive();
        repeat (7) next_cycle();
        chk("t5_count_full", 32'(bus.o_count), 32'd4);
        chk("t5_head", bus.o_act, mk_act(1, 2, 3, 4));
        bus.o_ready = 1'b1;
        next_cycle();
        chk("t5_count_pushpop", 32'(bus.o_count), 32'd4);
        chk("t5_no_ovf", 32'(bus.o_overflow), 32'd0);
        for (int k = 1; k < 5; k++) begin
            chk("t5_drain_act", bus.o_act, mk_act(10 * k + 1, 10 * k + 2, 10 * k + 3, 10 * k + 4));
            next_cycle();
        end
        chk("t5_drained_valid", 32'(bus.o_valid), 32'd0);
        bus.o_ready = 1'b0;

        // Reset with two rows buffered and two in flight.
        c0 = cyc;
        add_row(c0, 1, 1, 1, 1, 5'd0, 1'b0);
        add_row(c0 + 1, 2, 2, 2, 2, 5'd0, 1'b0);
        add_row(c0 + 4, 3, 3, 3, 3, 5'd0, 1'b0);
        add_row(c0 + 5, 4, 4, 4, 4, 5'd0, 1'b0);
        drive();
        repeat (6) next_cycle();
        chk("t6_count_before", 32'(bus.o_count), 32'd2);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        chk("t6_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("t6_rst_count", 32'(bus.o_count), 32'd0);
        chk("t6_rst_ovf", 32'(bus.o_overflow), 32'd0);
        chk("t6_rst_act", bus.o_act, 32'd0);
        repeat (8) begin
            next_cycle();
            chk("t6_no_stale", 32'(bus.o_valid), 32'd0);
        end
        c0 = cyc;
        add_row(c0, 5, 6, 7, 8, 5'd0, 1'b0);
        drive();
        repeat (4) next_cycle();
        chk("t6_recover_valid", 32'(bus.o_valid), 32'd1);
        chk("t6_recover_act", bus.o_act, mk_act(5, 6, 7, 8));
        chk("t6_recover_count", 32'(bus.o_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/psum_drain.md
# psum_drain

Drain-side collector for the systolic array. It captures the skewed 24-bit partial sums leaving the bottom row of PEs and deskews them into aligned rows. Each row is requantized (shift, optional ReLU, saturate) back to 8-bit activations and buffered in a FIFO behind a valid/ready output. This turns the array's accumulator output back into activation format for the next layer or for writeback.

## Interface
- COLS, 4, number of array columns drained (≥1)
- DEPTH, 4, output FIFO depth in rows (power of two, ≥2)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- i_valid  in  1  marks that column 0 of a new row is on i_sums this cycle
- i_sums  in  COLS*24  signed partial sums; slice j = bits [24j+23:24j] = column j
- i_shift  in  5  right-shift amount for requantization, sampled with i_valid
- i_relu  in  1  clamp negatives to zero, sampled with i_valid
- o_valid  out  1  FIFO head row available
- o_ready  in  1  consumer accepts head row when o_valid & o_ready
- o_act  out  COLS*8  signed 8-bit activations of head row; slice j = column j
- o_count  out  clog2(DEPTH+1)  FIFO occupancy
- o_overflow  out  1  sticky: an aligned row was dropped because the FIFO was full

## Operation
- Skew contract: a row tagged by i_valid in cycle t presents column j's sum on slice j in cycle t+j.
- Deskew: column j passes through COLS−j register stages. The i_valid tag, i_shift and i_relu travel through a COLS-stage pipeline. Row config is therefore frozen at tag time, and later changes never affect in-flight rows.
- Back-to-back rows (i_valid every cycle) are supported. Deskew never stalls.
- Requant per column, combinational on the aligned stage:
  - x = sum >>> shift, arithmetic (floor toward −inf).
  - If relu and x<0 then x=0.
  - Saturate to [−128,127].
- FIFO write on aligned-tag:
  - Write is accepted if not full, or if full and a pop occurs the same cycle.
  - Otherwise the row is dropped and o_overflow is set.
  - o_overflow stays set until reset.
- Pop when o_valid & o_ready. o_act holds stable while o_valid & !o_ready.
- Push and pop in the same cycle leave o_count unchanged.
- Reset values: o_valid=0, o_act=0, o_count=0, o_overflow=0. All deskew and tag stages are cleared.
- Reset mid-operation discards in-flight and buffered rows. No o_valid in the first cycle after reset deasserts.

## Timing
- i_valid in cycle t → aligned row written at edge ending cycle t+COLS−1 → o_valid in cycle t+COLS when the FIFO was empty (COLS cycles latency; 4 with defaults).
- Rows leave in arrival order. Throughput is one row per cycle with o_ready held high.
- o_count updates the cycle after each push/pop edge.
- o_overflow rises in the cycle after the dropped write.
- Full boundary: with DEPTH rows buffered and o_ready=0, the next aligned row is dropped. With o_ready=1 in the same cycle it is accepted and o_count stays DEPTH.
- Empty boundary: o_valid=0 and o_ready is ignored. There is no bypass from the aligned stage to the output in the same cycle.

## Structure
- Shared package: SUM_W=24, ACT_W=8, SHIFT_W=5 constants, and a requant function (sum, shift, relu → 8-bit). The function is shared with any future bias/scale unit.
- Sub-module row_fifo: synchronous FIFO with parameterized width and DEPTH. It provides push/pop, full/empty and count, and supports simultaneous push and pop when full.
- Top level holds the per-column deskew chains, the tag/config pipeline, the requant lanes and the overflow flag.

## Test plan
- Single row, COLS=4, shift=3, relu=0, sums {1000,2000,−300,−1}, each on its skewed cycle → o_act {125,127,−38,−1}, o_valid in cycle t+4.
- Same sums with relu=1, shift=0 → {127,127,0,0}. Sum 127 → 127; sum 128 → 127; sum −129 → −128.
- Eight back-to-back rows with o_ready=1 → eight consecutive o_valid cycles in order, o_count ≤1, o_overflow=0.
- o_ready=0, five rows with DEPTH=4 → o_count=4, fifth row dropped, o_overflow=1. Then drain → four rows out, o_overflow remains 1.
- Full FIFO, o_ready=1 on the same cycle the aligned row arrives → row accepted, o_count stays 4, no overflow.
- Reset asserted with two rows in flight and two buffered → o_valid=0, o_count=0, o_overflow=0. No stale rows appear afterward.
